dac_writer: RTL and testbench
=============================

# dac_writer

Serial transmitter for the 12-bit output DAC. It is the write-side counterpart of the ADC serial reader and uses the same three-wire style of link: an active-low chip select, a free-running-when-framed `sclk`, and one data line. It accepts a parallel code plus a power-down mode and shifts out one 16-bit frame, MSB first. The frame format is two zero bits, then `mode[1:0]`, then `value[11:0]`. The block sits between the control/modulation logic and the DAC pins.

## Interface
- `HALF_PERIOD`, default 10: `clk` cycles per `sclk` half-period; must be ≥1.
- `IDLE_GAP`, default 2: number of `sclk` periods with `cs` high between frames; must be ≥1.

- `clk`  in  1  system clock; all logic runs on its rising edge; no derived clocks.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `write`  in  1  request to send a frame; level-sampled.
- `value`  in  12  DAC code; sampled only on accept.
- `mode`  in  2  DAC power-down bits (00 = normal); sampled only on accept.
- `cs`  out  1  DAC sync/chip select, active-low.
- `sclk`  out  1  serial clock; idles high.
- `sdi`  out  1  serial data to the DAC.
- `busy`  out  1  high from accept until the inter-frame gap ends.
- `write_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Registers:
  - frame shift register, 16 bits;
  - half-period counter, width `$clog2(HALF_PERIOD+1)`;
  - bit counter, 4 bits, counting 15 down to 0;
  - gap counter.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - Outputs: `cs`=1, `sclk`=1, `sdi`=0, `busy`=0.
  - On an edge where `write`=1: load frame = {2'b00, `mode`, `value`}, set `cs`=0, `busy`=1, `sdi`=frame[15], bit counter=15, then go to SHIFT.
- SHIFT:
  - Each bit lasts 2·HALF_PERIOD cycles: the first half has `sclk`=1, the second half has `sclk`=0.
  - The DAC samples on the falling `sclk` edge, in the middle of the bit.
  - At the end of each bit's low half, `sclk` returns to 1 and `sdi` advances to the next bit, on the same edge.
  - At the end of bit 0's low half: `sclk`=1, `cs`=1, `sdi`=0, `write_done`=1 for exactly one cycle, then go to GAP.
- GAP:
  - Hold `cs`=1 and `busy`=1 for IDLE_GAP·2·HALF_PERIOD cycles, then go to IDLE with `busy`=0.
- `write` while `busy`=1 is ignored, not queued. Changes to `value`/`mode` after accept have no effect on the frame in flight.
- `write` held high continuously produces back-to-back frames separated by the gap.
- `reset` low at any time, including mid-frame:
  - Immediately, without waiting for `clk`: `cs`=1, `sclk`=1, `sdi`=0, `busy`=0, `write_done`=0; state returns to IDLE and all counters are cleared.
  - The DAC discards a frame whose sync rises before the 16th falling edge, so an aborted frame has no effect on its output.

## Timing
- Reset values: `cs`=1, `sclk`=1, `sdi`=0, `busy`=0, `write_done`=0.
- Accept edge = edge A, where `write`=1 and state is IDLE. `cs`, `busy` and `sdi`=bit15 are all valid after edge A.
- First `sclk` falling edge: HALF_PERIOD cycles after A.
- `cs` low duration: exactly 32·HALF_PERIOD cycles. The frame contains exactly 16 falling `sclk` edges.
- `sdi` setup to each falling edge: HALF_PERIOD cycles. `sdi` hold after each falling edge: HALF_PERIOD cycles.
- `write_done` is high in the cycle `cs` returns high, i.e. A + 32·HALF_PERIOD.
- `busy` falls at A + 32·HALF_PERIOD + 2·HALF_PERIOD·IDLE_GAP. The next accept can occur on that same edge if `write`=1.
- Minimum frame-to-frame period: 2·HALF_PERIOD·(16+IDLE_GAP) cycles.

## Test plan
- **Reset values:** assert `reset`=0 with random inputs → `cs`=1, `sclk`=1, `sdi`=0, `busy`=0, `write_done`=0, independent of `clk`.
- **Single frame:** HALF_PERIOD=2, `value`=12'hA5C, `mode`=00, 1-cycle `write` pulse → `sdi` sampled at the 16 `sclk` falling edges reads 0000_1010_0101_1100. `cs` is low for 64 cycles. `write_done` is a single pulse at A+64. `busy` falls at A+72 (IDLE_GAP=2).
- **Write while busy:** pulse `write` with `value`=12'h123 at A+10 and again in the gap → ignored; exactly one frame is sent, carrying the original code.
- **Back-to-back:** `write` held high, `value`=12'h001 → consecutive frames each have 16 falling edges, and `cs` is high for exactly 2·HALF_PERIOD·IDLE_GAP cycles between them.
- **Reset mid-frame:** assert `reset` after the 7th falling edge → `cs`/`sclk` go high asynchronously. After release, a `write` with `value`=12'h800 yields a complete frame of 0x0800.
- **Full-scale, minimum divider:** HALF_PERIOD=1, `mode`=11, `value`=12'hFFF → frame 0x3FFF; 16 falling edges within 32 cycles of `cs` low.

Source files
------------

// File: rtl/dac_writer.sv
// rtl/dac_writer.sv - 16-bit frame serial transmitter for the 12-bit output DAC
module dac_writer #(
    parameter int HALF_PERIOD = 10,
    parameter int IDLE_GAP    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [11:0] value,
    input  logic [1:0]  mode,
    output logic        cs,
    output logic        sclk,
    output logic        sdi,
    output logic        busy,
    output logic        write_done
);

    localparam int HW         = $clog2(HALF_PERIOD + 1);
    localparam int GAP_CYCLES = 2 * HALF_PERIOD * IDLE_GAP;
    localparam int GW         = $clog2(GAP_CYCLES + 1);

    // Counters count down to zero; reload values make each interval span exactly its length.
    localparam logic [HW-1:0] HALF_RELOAD = HW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     frame_q, frame_d;
    logic [HW-1:0]   half_cnt_q, half_cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            cs_q, cs_d;
    logic            sclk_q, sclk_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            half_end;
    logic            last_bit;
    logic            gap_end;
    logic            accept;

    assign half_end = (half_cnt_q == '0);
    assign last_bit = (bit_cnt_q == 4'd0);
    assign gap_end  = (gap_cnt_q == '0);
    // A new frame may start from idle, or on the very edge the inter-frame gap expires.
    assign accept   = write && ((state_q == S_IDLE) || ((state_q == S_GAP) && gap_end));

    // The MSB of the shift register drives the data line; it is cleared whenever no frame is active.
    assign sdi        = frame_q[15];
    assign cs         = cs_q;
    assign sclk       = sclk_q;
    assign busy       = busy_q;
    assign write_done = done_q;

    // State and datapath registers; reset puts the link into its idle, deselected state at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state selection: a frame ends at the close of bit 0's low half.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (half_end && !sclk_q && last_bit) state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_end) state_d = accept ? S_SHIFT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame loading, bit timing and pin values for the next cycle.
    always_comb begin
        frame_d    = frame_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (accept) begin
            frame_d    = {2'b00, mode, value};
            half_cnt_d = HALF_RELOAD;
            bit_cnt_d  = 4'd15;
            cs_d       = 1'b0;
            sclk_d     = 1'b1;
            busy_d     = 1'b1;
        end else begin
            unique case (state_q)
                S_SHIFT: begin
                    if (!half_end) begin
                        half_cnt_d = half_cnt_q - 1'b1;
                    end else begin
                        half_cnt_d = HALF_RELOAD;
                        if (sclk_q) begin
                            // Mid-bit: falling edge, the DAC samples the stable data here.
                            sclk_d = 1'b0;
                        end else if (last_bit) begin
                            frame_d   = '0;
                            cs_d      = 1'b1;
                            sclk_d    = 1'b1;
                            done_d    = 1'b1;
                            gap_cnt_d = GAP_RELOAD;
                        end else begin
                            // Rising edge and data advance happen together.
                            frame_d   = {frame_q[14:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 4'd1;
                            sclk_d    = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_end) begin
                        busy_d = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    cs_d   = 1'b1;
                    sclk_d = 1'b1;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_writer.sv
// tb/tb_dac_writer.sv - directed self-checking bench for dac_writer
module tb_dac_writer;

    logic        clk;
    logic        rst_n;
    logic        write0, write1;
    logic [11:0] value0, value1;
    logic [1:0]  mode0, mode1;
    logic        cs0, sclk0, sdi0, busy0, done0;
    logic        cs1, sclk1, sdi1, busy1, done1;

    int tests_run;
    int tests_failed;

    dac_writer #(.HALF_PERIOD(2), .IDLE_GAP(2)) u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .write      (write0),
        .value      (value0),
        .mode       (mode0),
        .cs         (cs0),
        .sclk       (sclk0),
        .sdi        (sdi0),
        .busy       (busy0),
        .write_done (done0)
    );

    dac_writer #(.HALF_PERIOD(1), .IDLE_GAP(2)) u_dut_fast (
        .clk        (clk),
        .reset      (rst_n),
        .write      (write1),
        .value      (value1),
        .mode       (mode1),
        .cs         (cs1),
        .sclk       (sclk1),
        .sdi        (sdi1),
        .busy       (busy1),
        .write_done (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one frame on the HALF_PERIOD=2 instance and measures it; k counts edges after accept.
    task automatic run_frame(input logic [11:0] v, input logic [1:0] m, input int p1, input int p2,
                             output logic [15:0] bits, output int falls, output int cs_low,
                             output int done_cnt, output int done_at, output int busy_fall_at);
        logic prev_sclk;
        bits = '0; falls = 0; cs_low = 0; done_cnt = 0; done_at = -1; busy_fall_at = -1;
        @(negedge clk);
        write0 = 1'b1; value0 = v; mode0 = m;
        @(posedge clk);
        prev_sclk = 1'b1;
        for (int k = 0; k < 200 && busy_fall_at < 0; k++) begin
            @(negedge clk);
            write0 = 1'b0;
            if (k == 0) begin value0 = ~v; mode0 = ~m; end
            if (k == p1 - 1 || k == p2 - 1) begin write0 = 1'b1; value0 = 12'h123; end
            if (prev_sclk && !sclk0) begin bits = {bits[14:0], sdi0}; falls++; end
            if (!cs0) cs_low++;
            if (done0) begin done_cnt++; done_at = k; end
            if (!busy0) busy_fall_at = k;
            prev_sclk = sclk0;
        end
        write0 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        write0 = 1'b0; value0 = '0; mode0 = '0;
        write1 = 1'b0; value1 = '0; mode1 = '0;
        #2;
        rst_n = 1'b0;
        write0 = 1'($urandom); value0 = 12'($urandom); mode0 = 2'($urandom);
        write1 = 1'($urandom); value1 = 12'($urandom); mode1 = 2'($urandom);
        #1;
        tests_run++; if (cs0 !== 1'b1)   begin tests_failed++; $display("FAIL reset_cs got=%b exp=1", cs0); end
        tests_run++; if (sclk0 !== 1'b1) begin tests_failed++; $display("FAIL reset_sclk got=%b exp=1", sclk0); end
        tests_run++; if (sdi0 !== 1'b0)  begin tests_failed++; $display("FAIL reset_sdi got=%b exp=0", sdi0); end
        tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy0); end
        tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done0); end
        repeat (3) begin
            @(negedge clk);
            write0 = 1'($urandom); value0 = 12'($urandom);
            write1 = 1'($urandom); value1 = 12'($urandom);
        end
        tests_run++; if ({cs0, sclk0, sdi0, busy0} !== 4'b1100) begin tests_failed++; $display("FAIL reset_held got=%b exp=1100", {cs0, sclk0, sdi0, busy0}); end
        tests_run++; if ({cs1, sclk1, sdi1, busy1, done1} !== 5'b11000) begin tests_failed++; $display("FAIL reset_fast got=%b exp=11000", {cs1, sclk1, sdi1, busy1, done1}); end
        write0 = 1'b0; write1 = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        logic [15:0] bits; int falls, cs_low, done_cnt, done_at, busy_at;
        run_frame(12'hA5C, 2'b00, -1, -1, bits, falls, cs_low, done_cnt, done_at, busy_at);
        tests_run++; if (bits !== 16'h0A5C) begin tests_failed++; $display("FAIL single_bits got=%h exp=0a5c", bits); end
        tests_run++; if (falls !== 16)      begin tests_failed++; $display("FAIL single_falls got=%0d exp=16", falls); end
        tests_run++; if (cs_low !== 64)     begin tests_failed++; $display("FAIL single_cs_low got=%0d exp=64", cs_low); end
        tests_run++; if (done_cnt !== 1)    begin tests_failed++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
        tests_run++; if (done_at !== 64)    begin tests_failed++; $display("FAIL single_done_at got=%0d exp=64", done_at); end
        tests_run++; if (busy_at !== 72)    begin tests_failed++; $display("FAIL single_busy_fall got=%0d exp=72", busy_at); end
    endtask

    task automatic test_write_while_busy;
        logic [15:0] bits; int falls, cs_low, done_cnt, done_at, busy_at; int extra_cs;
        run_frame(12'h5A3, 2'b00, 10, 68, bits, falls, cs_low, done_cnt, done_at, busy_at);
        extra_cs = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cs0) extra_cs++;
        end
        tests_run++; if (bits !== 16'h05A3) begin tests_failed++; $display("FAIL busy_bits got=%h exp=05a3", bits); end
        tests_run++; if (falls !== 16)      begin tests_failed++; $display("FAIL busy_falls got=%0d exp=16", falls); end
        tests_run++; if (busy_at !== 72)    begin tests_failed++; $display("FAIL busy_fall got=%0d exp=72", busy_at); end
        tests_run++; if (extra_cs !== 0)    begin tests_failed++; $display("FAIL busy_extra_frame got=%0d exp=0", extra_cs); end
    endtask

    task automatic test_back_to_back;
        logic prev_sclk, prev_cs;
        int frame_no, gap_high;
        int falls [2];
        logic [15:0] bits [2];
        frame_no = 0; gap_high = 0;
        falls[0] = 0; falls[1] = 0; bits[0] = '0; bits[1] = '0;
        @(negedge clk);
        write0 = 1'b1; value0 = 12'h001; mode0 = 2'b00;
        @(posedge clk);
        prev_sclk = 1'b1; prev_cs = 1'b0;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            if (k == 140) write0 = 1'b0;
            if (prev_cs && !cs0) frame_no++;
            if (frame_no < 2 && prev_sclk && !sclk0) begin
                bits[frame_no] = {bits[frame_no][14:0], sdi0};
                falls[frame_no]++;
            end
            if (frame_no == 0 && cs0) gap_high++;
            prev_sclk = sclk0; prev_cs = cs0;
        end
        write0 = 1'b0;
        tests_run++; if (frame_no !== 1)       begin tests_failed++; $display("FAIL b2b_frames got=%0d exp=1", frame_no); end
        tests_run++; if (falls[0] !== 16)      begin tests_failed++; $display("FAIL b2b_falls0 got=%0d exp=16", falls[0]); end
        tests_run++; if (falls[1] !== 16)      begin tests_failed++; $display("FAIL b2b_falls1 got=%0d exp=16", falls[1]); end
        tests_run++; if (bits[0] !== 16'h0001) begin tests_failed++; $display("FAIL b2b_bits0 got=%h exp=0001", bits[0]); end
        tests_run++; if (bits[1] !== 16'h0001) begin tests_failed++; $display("FAIL b2b_bits1 got=%h exp=0001", bits[1]); end
        tests_run++; if (gap_high !== 8)       begin tests_failed++; $display("FAIL b2b_gap got=%0d exp=8", gap_high); end
        tests_run++; if (busy0 !== 1'b0)       begin tests_failed++; $display("FAIL b2b_idle_busy got=%b exp=0", busy0); end
    endtask

    task automatic test_reset_mid_frame;
        logic prev_sclk; int falls_seen;
        logic [15:0] bits; int falls, cs_low, done_cnt, done_at, busy_at;
        falls_seen = 0;
        @(negedge clk);
        write0 = 1'b1; value0 = 12'h5A5; mode0 = 2'b00;
        @(posedge clk);
        prev_sclk = 1'b1;
        for (int k = 0; k < 100 && falls_seen < 7; k++) begin
            @(negedge clk);
            write0 = 1'b0;
            if (prev_sclk && !sclk0) falls_seen++;
            prev_sclk = sclk0;
        end
        tests_run++; if (falls_seen !== 7) begin tests_failed++; $display("FAIL mid_reach7 got=%0d exp=7", falls_seen); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++; if ({cs0, sclk0, sdi0, busy0, done0} !== 5'b11000) begin tests_failed++; $display("FAIL mid_async got=%b exp=11000", {cs0, sclk0, sdi0, busy0, done0}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(12'h800, 2'b00, -1, -1, bits, falls, cs_low, done_cnt, done_at, busy_at);
        tests_run++; if (bits !== 16'h0800) begin tests_failed++; $display("FAIL mid_bits got=%h exp=0800", bits); end
        tests_run++; if (falls !== 16)      begin tests_failed++; $display("FAIL mid_falls got=%0d exp=16", falls); end
        tests_run++; if (done_cnt !== 1)    begin tests_failed++; $display("FAIL mid_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_full_scale;
        logic prev_sclk; logic [15:0] bits;
        int falls, cs_low, done_at, busy_at;
        bits = '0; falls = 0; cs_low = 0; done_at = -1; busy_at = -1;
        @(negedge clk);
        write1 = 1'b1; value1 = 12'hFFF; mode1 = 2'b11;
        @(posedge clk);
        prev_sclk = 1'b1;
        for (int k = 0; k < 100 && busy_at < 0; k++) begin
            @(negedge clk);
            write1 = 1'b0;
            if (k == 0) begin value1 = 12'h000; mode1 = 2'b00; end
            if (prev_sclk && !sclk1) begin bits = {bits[14:0], sdi1}; falls++; end
            if (!cs1) cs_low++;
            if (done1) done_at = k;
            if (!busy1) busy_at = k;
            prev_sclk = sclk1;
        end
        tests_run++; if (bits !== 16'h3FFF) begin tests_failed++; $display("FAIL fast_bits got=%h exp=3fff", bits); end
        tests_run++; if (falls !== 16)      begin tests_failed++; $display("FAIL fast_falls got=%0d exp=16", falls); end
        tests_run++; if (cs_low !== 32)     begin tests_failed++; $display("FAIL fast_cs_low got=%0d exp=32", cs_low); end
        tests_run++; if (done_at !== 32)    begin tests_failed++; $display("FAIL fast_done_at got=%0d exp=32", done_at); end
        tests_run++; if (busy_at !== 36)    begin tests_failed++; $display("FAIL fast_busy_fall got=%0d exp=36", busy_at); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_frame();
        test_write_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_full_scale();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
